// File: rtl/pkt_gen_out.sv
// Packet generator: turns AXI write beats into NoC flits (head + one flit per beat)
// behind a single output register that is gated by the router's per-VC ready.
module pkt_gen_out #(
  parameter int FLIT_WIDTH    = 34,
  parameter int FLIT_TP_WIDTH = 2,
  parameter int N_VIRT_CHN    = 3,
  parameter int VC_WIDTH      = 2,
  parameter int X_WIDTH       = 2,
  parameter int Y_WIDTH       = 2,
  parameter int PKT_SZ_WIDTH  = 9
) (
  input  logic                                clk,
  input  logic                                arst,
  input  logic                                req_valid_i,
  input  logic                                req_new_i,
  input  logic                                req_last_i,
  input  logic [VC_WIDTH-1:0]                 req_vc_id_i,
  input  logic [PKT_SZ_WIDTH-1:0]             req_pkt_sz_i,
  input  logic [FLIT_WIDTH-FLIT_TP_WIDTH-1:0] req_flit_data_i,
  output logic                                req_ready_o,
  input  logic [X_WIDTH-1:0]                  x_dest_i,
  input  logic [Y_WIDTH-1:0]                  y_dest_i,
  output logic [FLIT_WIDTH-1:0]               flit_o,
  output logic [VC_WIDTH-1:0]                 flit_vc_o,
  output logic                                flit_valid_o,
  input  logic [N_VIRT_CHN-1:0]               vc_ready_i,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int PW = FLIT_WIDTH - FLIT_TP_WIDTH;
  localparam int HW = X_WIDTH + Y_WIDTH + PKT_SZ_WIDTH;

  localparam logic [FLIT_TP_WIDTH-1:0] TP_HEAD = FLIT_TP_WIDTH'(2'b00);
  localparam logic [FLIT_TP_WIDTH-1:0] TP_BODY = FLIT_TP_WIDTH'(2'b01);
  localparam logic [FLIT_TP_WIDTH-1:0] TP_TAIL = FLIT_TP_WIDTH'(2'b10);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BODY = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic                      valid_q, valid_d;
  logic [FLIT_WIDTH-1:0]     flit_q, flit_d;
  logic [VC_WIDTH-1:0]       vc_q, vc_d;
  logic [VC_WIDTH-1:0]       vc_lat_q, vc_lat_d;
  logic [PKT_SZ_WIDTH-1:0]   sz_lat_q, sz_lat_d;
  logic [PKT_SZ_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic                      err_q, err_d;

  logic                      out_free_s;
  logic                      xfer_s;
  logic                      head_ld_s;
  logic                      body_acc_s;
  logic                      orphan_s;
  logic                      exp_last_s;
  logic                      is_tail_s;
  logic [PKT_SZ_WIDTH:0]     cnt_p1_s;

  // Ready of one VC; VC ids beyond N_VIRT_CHN read as not ready.
  function automatic logic vc_rdy(input logic [N_VIRT_CHN-1:0] rdy,
                                  input logic [VC_WIDTH-1:0]   vc);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_VIRT_CHN; i++) begin
      r = r | ((vc == VC_WIDTH'(i)) & rdy[i]);
    end
    return r;
  endfunction

  assign out_free_s = ~valid_q | vc_rdy(vc_ready_i, vc_q);
  assign xfer_s     = valid_q & vc_rdy(vc_ready_i, vc_q);
  assign cnt_p1_s   = {1'b0, beat_cnt_q} + (PKT_SZ_WIDTH+1)'(1);
  assign exp_last_s = (cnt_p1_s >= {1'b0, sz_lat_q});
  assign is_tail_s  = req_last_i | exp_last_s;

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (head_ld_s) state_d = S_BODY;
        else           state_d = S_IDLE;
      end
      S_BODY: begin
        if (body_acc_s && is_tail_s) state_d = S_IDLE;
        else                         state_d = S_BODY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: beat handshake and load strobes
  always_comb begin
    req_ready_o = 1'b0;
    head_ld_s   = 1'b0;
    body_acc_s  = 1'b0;
    orphan_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The head beat is left pending; only orphan beats are swallowed here.
        req_ready_o = req_valid_i & ~req_new_i;
        head_ld_s   = req_valid_i & req_new_i & out_free_s;
        orphan_s    = req_valid_i & ~req_new_i;
      end
      S_BODY: begin
        req_ready_o = out_free_s;
        body_acc_s  = req_valid_i & out_free_s;
      end
      default: begin
        req_ready_o = 1'b0;
      end
    endcase
  end

  // Datapath next-state: output stage, packet context, error pulse
  always_comb begin
    valid_d    = valid_q;
    flit_d     = flit_q;
    vc_d       = vc_q;
    vc_lat_d   = vc_lat_q;
    sz_lat_d   = sz_lat_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = orphan_s | (body_acc_s & (req_last_i != exp_last_s));
    if (head_ld_s) begin
      valid_d    = 1'b1;
      flit_d     = {TP_HEAD, {(PW-HW){1'b0}}, x_dest_i, y_dest_i, req_pkt_sz_i};
      vc_d       = req_vc_id_i;
      vc_lat_d   = req_vc_id_i;
      sz_lat_d   = req_pkt_sz_i;
      beat_cnt_d = '0;
    end else if (body_acc_s) begin
      valid_d    = 1'b1;
      flit_d     = {(is_tail_s ? TP_TAIL : TP_BODY), req_flit_data_i};
      vc_d       = vc_lat_q;
      beat_cnt_d = beat_cnt_q + PKT_SZ_WIDTH'(1);
    end else if (xfer_s) begin
      valid_d    = 1'b0;
    end else begin
      valid_d    = valid_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q    <= 1'b0;
      flit_q     <= '0;
      vc_q       <= '0;
      vc_lat_q   <= '0;
      sz_lat_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      flit_q     <= flit_d;
      vc_q       <= vc_d;
      vc_lat_q   <= vc_lat_d;
      sz_lat_q   <= sz_lat_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign flit_o       = flit_q;
  assign flit_vc_o    = vc_q;
  assign flit_valid_o = valid_q;
  assign busy_o       = (state_q == S_BODY);
  assign err_o        = err_q;

endmodule

// File: tb/tb_pkt_gen_out.sv
// Scoreboard bench for pkt_gen_out: directed packets push expected flits,
// a negedge monitor pops and compares every flit the router accepts.
module tb_pkt_gen_out;

  logic        clk = 1'b0;
  logic        arst;
  logic        req_valid_i, req_new_i, req_last_i;
  logic [1:0]  req_vc_id_i;
  logic [8:0]  req_pkt_sz_i;
  logic [31:0] req_flit_data_i;
  logic        req_ready_o;
  logic [1:0]  x_dest_i, y_dest_i;
  logic [33:0] flit_o;
  logic [1:0]  flit_vc_o;
  logic        flit_valid_o;
  logic [2:0]  vc_ready_i;
  logic        busy_o, err_o;

  pkt_gen_out dut (
    .clk(clk), .arst(arst),
    .req_valid_i(req_valid_i), .req_new_i(req_new_i), .req_last_i(req_last_i),
    .req_vc_id_i(req_vc_id_i), .req_pkt_sz_i(req_pkt_sz_i),
    .req_flit_data_i(req_flit_data_i), .req_ready_o(req_ready_o),
    .x_dest_i(x_dest_i), .y_dest_i(y_dest_i),
    .flit_o(flit_o), .flit_vc_o(flit_vc_o), .flit_valid_o(flit_valid_o),
    .vc_ready_i(vc_ready_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  logic [35:0] exp_q[$];
  int          xfer_t[$];
  int          checks = 0, errors = 0, err_cnt = 0, cyc = 0;
  logic [35:0] mon_e;

  always @(posedge clk) cyc++;

  // Monitor: every accepted flit must match the head of the expectation queue
  always @(negedge clk) begin
    if (!arst && flit_valid_o && vc_ready_i[flit_vc_o]) begin
      xfer_t.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flit got vc=%0d flit=%h, none expected", flit_vc_o, flit_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({flit_vc_o, flit_o} !== mon_e) begin
          errors++;
          $display("FAIL flit got vc=%0d flit=%h required vc=%0d flit=%h",
                   flit_vc_o, flit_o, mon_e[35:34], mon_e[33:0]);
        end
      end
    end
    if (!arst && err_o) err_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  // Hold the current beat until it is accepted; returns just after the accepting edge.
  task automatic send_beat();
    int  n = 0;
    bit  done = 0;
    logic rdy;
    while (!done && n < 200) begin
      @(negedge clk);
      rdy = req_ready_o;
      @(posedge clk);
      #1;
      if (rdy) done = 1;
      n++;
    end
    if (!done) chk("beat_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_pkt(input logic [1:0] vc, input logic [1:0] x, input logic [1:0] y,
                          input logic [8:0] sz, input int nb, input int last_at,
                          input logic [31:0] base);
    exp_q.push_back({vc, 2'b00, 19'd0, x, y, sz});
    req_vc_id_i = vc; x_dest_i = x; y_dest_i = y; req_pkt_sz_i = sz;
    for (int i = 1; i <= nb; i++) begin
      bit lst, tl;
      lst = (i == last_at);
      tl  = lst || (i >= sz);
      exp_q.push_back({vc, (tl ? 2'b10 : 2'b01), base + 32'(i)});
      req_valid_i = 1'b1; req_new_i = (i == 1); req_last_i = lst;
      req_flit_data_i = base + 32'(i);
      send_beat();
      if (tl) break;
    end
    req_valid_i = 1'b0; req_new_i = 1'b0; req_last_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int e0, n0;
  logic [33:0] hold;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; req_valid_i = 0; req_new_i = 0; req_last_i = 0; req_vc_id_i = 0;
    req_pkt_sz_i = 0; req_flit_data_i = 0; x_dest_i = 0; y_dest_i = 0; vc_ready_i = 3'b111;
    #1;
    chk("rst_valid", 64'(flit_valid_o), 64'd0);
    chk("rst_flit",  64'(flit_o), 64'd0);
    chk("rst_vc",    64'(flit_vc_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_err",   64'(err_o), 64'd0);
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    idle(1);

    // 1: basic packet, flits on consecutive cycles
    e0 = err_cnt; n0 = xfer_t.size();
    send_pkt(2'd1, 2'd1, 2'd2, 9'd3, 3, 3, 32'hA000_0000);
    idle(3);
    chk("basic_nflits", 64'(xfer_t.size() - n0), 64'd4);
    for (int k = 1; k < 4; k++) chk("basic_gap", 64'(xfer_t[n0+k] - xfer_t[n0+k-1]), 64'd1);
    chk("basic_err", 64'(err_cnt - e0), 64'd0);

    // 2: single-beat packet
    e0 = err_cnt;
    send_pkt(2'd2, 2'd3, 2'd0, 9'd1, 1, 1, 32'hD000_0000);
    idle(3);
    chk("single_busy", 64'(busy_o), 64'd0);
    chk("single_err",  64'(err_cnt - e0), 64'd0);

    // 3: backpressure on VC1; VC0 ready toggles without effect
    e0 = err_cnt;
    fork
      send_pkt(2'd1, 2'd0, 2'd1, 9'd6, 6, 6, 32'hB000_0000);
      begin
        repeat (3) @(posedge clk);
        #1 vc_ready_i[1] = 1'b0;
        @(negedge clk);
        hold = flit_o;
        chk("bp_ready", 64'(req_ready_o), 64'd0);
        repeat (3) begin
          @(posedge clk);
          #1 vc_ready_i[0] = ~vc_ready_i[0];
          @(negedge clk);
          chk("bp_stable", 64'(flit_o), 64'(hold));
          chk("bp_ready",  64'(req_ready_o), 64'd0);
        end
        @(posedge clk);
        #1 vc_ready_i = 3'b111;
      end
    join
    idle(3);
    chk("bp_err", 64'(err_cnt - e0), 64'd0);

    // 4a: early last
    e0 = err_cnt;
    send_pkt(2'd0, 2'd2, 2'd2, 9'd4, 2, 2, 32'hC000_0000);
    idle(3);
    chk("early_last_err", 64'(err_cnt - e0), 64'd1);

    // 4b: missing last
    e0 = err_cnt;
    send_pkt(2'd2, 2'd1, 2'd1, 9'd2, 2, 0, 32'hC100_0000);
    idle(3);
    chk("missing_last_err", 64'(err_cnt - e0), 64'd1);

    // 5: orphan beat in IDLE
    e0 = err_cnt; n0 = xfer_t.size();
    req_valid_i = 1'b1; req_new_i = 1'b0; req_flit_data_i = 32'hEEEE_EEEE;
    send_beat();
    req_valid_i = 1'b0;
    idle(3);
    chk("orphan_err",   64'(err_cnt - e0), 64'd1);
    chk("orphan_noflit", 64'(xfer_t.size() - n0), 64'd0);

    // 6: reset after head and one body
    exp_q.push_back({2'd1, 2'b00, 19'd0, 2'd3, 2'd3, 9'd4});
    req_vc_id_i = 2'd1; x_dest_i = 2'd3; y_dest_i = 2'd3; req_pkt_sz_i = 9'd4;
    exp_q.push_back({2'd1, 2'b01, 32'hF000_0001});
    req_valid_i = 1'b1; req_new_i = 1'b1; req_last_i = 1'b0; req_flit_data_i = 32'hF000_0001;
    send_beat();
    req_valid_i = 1'b0; req_new_i = 1'b0;
    arst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(flit_valid_o), 64'd0);
    chk("rst_mid_busy",  64'(busy_o), 64'd0);
    chk("rst_mid_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    @(negedge clk);
    arst = 1'b0;
    idle(1);
    send_pkt(2'd0, 2'd1, 2'd3, 9'd2, 2, 2, 32'h5000_0000);
    idle(4);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_gen_out.md
Name: pkt_gen_out

Overview:
- Packet generator sitting directly downstream of the NI AXI slave write path.
- Consumes per-beat write requests (vc id, new/last markers, packet size, payload) and emits NoC flits into the local router input port.
- Each packet is one head flit carrying destination and size, then one flit per AXI beat; the final beat is typed tail.
- Provides the ready that the AXI slave uses as wready, and drives a single registered output stage gated by per-VC router credit/ready.

Parameters:
- FLIT_WIDTH, 34: total flit width.
- FLIT_TP_WIDTH, 2: flit type field width, in flit MSBs.
- N_VIRT_CHN, 3: number of virtual channels.
- VC_WIDTH, 2: VC id width.
- X_WIDTH, 2: X destination width.
- Y_WIDTH, 2: Y destination width.
- PKT_SZ_WIDTH, 9: packet size (beats) width; holds 1..256.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- req_valid_i  in  1  beat valid from AXI slave
- req_new_i  in  1  beat is the first of a packet
- req_last_i  in  1  beat is the last of a packet (AXI wlast)
- req_vc_id_i  in  VC_WIDTH  target VC
- req_pkt_sz_i  in  PKT_SZ_WIDTH  beats in packet (alen+1)
- req_flit_data_i  in  FLIT_WIDTH-FLIT_TP_WIDTH  beat payload
- req_ready_o  out  1  beat accepted when req_valid_i && req_ready_o
- x_dest_i  in  X_WIDTH  destination X, sampled at head
- y_dest_i  in  Y_WIDTH  destination Y, sampled at head
- flit_o  out  FLIT_WIDTH  flit to router
- flit_vc_o  out  VC_WIDTH  VC of flit_o
- flit_valid_o  out  1  flit_o valid
- vc_ready_i  in  N_VIRT_CHN  router ready per VC
- busy_o  out  1  packet in progress (state BODY)
- err_o  out  1  one-cycle pulse on protocol error

Behaviour:
- Flit types: HEAD=2'b00, BODY=2'b01, TAIL=2'b10.
- Head payload: low bits = {x_dest, y_dest, pkt_sz}; all other payload bits are 0.
- Body/tail payload: req_flit_data_i unchanged.
- Output register: valid_ff, flit_ff, vc_ff.
  - out_free = ~valid_ff || vc_ready_i[vc_ff].
  - A flit transfers when flit_valid_o && vc_ready_i[flit_vc_o].
  - flit_o and flit_vc_o hold stable while valid and not ready.
  - valid_ff clears on transfer unless reloaded in the same cycle.
- Reset: async assertion clears immediately, mid-packet included. Resulting values:
  - state=IDLE.
  - valid_ff=0, flit_ff=0, vc_ff=0.
  - beat_cnt=0.
  - req_ready_o=0, busy_o=0, err_o=0.
  - No partial packet resumes after reset.
- FSM IDLE:
  - req_ready_o=0 while req_new_i=1.
  - On req_valid_i && req_new_i && out_free:
    - latch vc, pkt_sz, x/y dest;
    - load head flit into the output register;
    - beat_cnt<=0; go to BODY.
  - The beat itself is not consumed; it is re-presented in BODY.
  - req_valid_i && ~req_new_i in IDLE: req_ready_o=1, beat dropped, err_o pulses.
- FSM BODY:
  - req_ready_o = out_free.
  - On accept: load the flit with vc = latched vc; beat_cnt++.
  - exp_last = (beat_cnt+1 >= latched pkt_sz). pkt_sz=0 therefore ends after one beat.
  - is_tail = req_last_i || exp_last; type TAIL if is_tail, else BODY.
  - err_o pulses if req_last_i != exp_last.
  - On tail accept, go to IDLE.
  - req_new_i and req_vc_id_i are ignored in BODY.
- Latency and throughput:
  - Head appears on flit_valid_o the cycle after the req_new beat is first presented.
  - First body is accepted in that same cycle if the head drains.
  - Steady state is 1 flit/cycle; packet overhead is 1 cycle.
- Backpressure: ~vc_ready_i[latched vc] stalls req_ready_o combinationally. Other VCs' ready is irrelevant.
- Simultaneous events: a transfer and a reload in the same cycle leave valid_ff=1 with the new flit.
- busy_o = (state==BODY).

Test Plan:
1. **Basic packet.**
   - Stimulus: x=1, y=2, vc=1, pkt_sz=3, payloads A,B,C, vc_ready all 1.
   - Required: flits HEAD{1,2,3}, BODY A, BODY B, TAIL C on consecutive cycles, flit_vc_o=1, err_o never set.
2. **Single beat.**
   - Stimulus: pkt_sz=1 with req_new and req_last on the same beat D.
   - Required: HEAD{..,1} then TAIL D; return to IDLE with busy_o=0.
3. **Backpressure.**
   - Stimulus: vc_ready_i[1]=0 for 4 cycles mid-packet.
   - Required: flit_o stable, req_ready_o=0 throughout; resumes with no loss or duplication. vc_ready_i[0] toggling has no effect.
4. **Size mismatch.**
   - Stimulus a: pkt_sz=4 with req_last on beat 2.
   - Required a: beat 2 typed TAIL, err_o pulses once.
   - Stimulus b: pkt_sz=2 with req_last never set.
   - Required b: beat 2 typed TAIL, err_o pulses.
5. **Orphan beat.**
   - Stimulus: req_valid_i=1, req_new_i=0 in IDLE.
   - Required: beat consumed, no flit emitted, err_o=1 for one cycle.
6. **Reset mid-packet.**
   - Stimulus: arst asserted after HEAD and 1 BODY.
   - Required: flit_valid_o=0 immediately; next packet starts with a fresh HEAD.
